// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between decode and a simple word bus.
//
// Accepts one load or store from decode while idle, places store bytes on the
// correct lanes, issues one or two word-aligned bus requests, and returns the
// sign- or zero-extended load result. The pipeline is held while the access is
// in flight.
//
// Configuration macro: LSU_SPLIT_EN
//   undefined : a misaligned access raises a one-cycle o_misalign pulse and
//               makes no bus access.
//   defined   : misaligned accesses are performed. An access that crosses a
//               word boundary is split into two bus requests, and load bytes
//               are merged before extension.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_mem_rden, i_mem_wren  load / store request (both high = store)
//   i_l_length, i_l_unsigned load size (funct3) and zero-extend select
//   i_s_length              store size
//   i_addr, i_st_data       byte address, right-aligned store data
//   o_stall                 pipeline hold
//   o_ld_data, o_ld_vld     load result and its one-cycle valid pulse
//   o_misalign              misaligned-access fault pulse
//   o_bus_*, i_bus_*        word bus request / response
module lsu_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_rden,
    input  logic        i_mem_wren,
    input  logic [2:0]  i_l_length,
    input  logic        i_l_unsigned,
    input  logic [1:0]  i_s_length,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic [31:0] o_ld_data,
    output logic        o_ld_vld,
    output logic        o_misalign,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

`ifdef LSU_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        REQ1  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    state_t              state;
    logic                load_q;
    logic                uns_q;
    size_t               size_q;
    logic [1:0]          off_q;
    logic                split_q;
    logic [BE_W-1:0]     be_hi_q;
    logic [XLEN-1:0]     lo_q;

    logic                req_c;
    size_t               size_c;
    logic [1:0]          off_c;
    logic [BE_W-1:0]     mask_c;
    logic [2*BE_W-1:0]   be8_c;
    logic                misal_c;
    logic                split_c;
    logic                fault_c;
    logic [XLEN-1:0]     wdata_c;

    // Rotate a word left by whole bytes.
    function automatic logic [XLEN-1:0] rotl_bytes(input logic [XLEN-1:0] d,
                                                   input logic [1:0]      off);
        logic [2*XLEN-1:0] t;
        t = {d, d} << {off, 3'b000};
        return t[2*XLEN-1:XLEN];
    endfunction

    // Pull the addressed bytes out of the {next word, first word} pair and extend.
    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] hi,
                                                     input logic [XLEN-1:0] lo,
                                                     input logic [1:0]      off,
                                                     input size_t           sz,
                                                     input logic            uns);
        logic [2*XLEN-1:0] t;
        logic [XLEN-1:0]   r;
        t = {hi, lo} >> {off, 3'b000};
        case (sz)
            SZ_B:    r = uns ? {24'h0, t[7:0]}  : {{24{t[7]}}, t[7:0]};
            SZ_H:    r = uns ? {16'h0, t[15:0]} : {{16{t[15]}}, t[15:0]};
            default: r = t[XLEN-1:0];
        endcase
        return r;
    endfunction

    // Decode of the incoming request: size, byte enables, lane data, alignment.
    always_comb begin
        req_c   = i_mem_rden | i_mem_wren;
        size_c  = SZ_W;
        off_c   = i_addr[1:0];
        mask_c  = 4'b1111;
        wdata_c = rotl_bytes(i_st_data, off_c);

        if (i_mem_wren) begin
            case (i_s_length)
                2'b00:   size_c = SZ_B;
                2'b01:   size_c = SZ_H;
                default: size_c = SZ_W;
            endcase
        end else begin
            case (i_l_length)
                3'b000, 3'b100: size_c = SZ_B;
                3'b001, 3'b101: size_c = SZ_H;
                default:        size_c = SZ_W;
            endcase
        end

        case (size_c)
            SZ_B: begin
                mask_c  = 4'b0001;
                wdata_c = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                mask_c  = 4'b0011;
                // Replication only lines up on even offsets; odd ones need the rotation.
                wdata_c = off_c[0] ? rotl_bytes(i_st_data, off_c)
                                   : {2{i_st_data[15:0]}};
            end
            default: begin
                mask_c  = 4'b1111;
                wdata_c = rotl_bytes(i_st_data, off_c);
            end
        endcase

        // Upper nibble of be8_c holds the lanes that spill into the next word.
        be8_c   = {4'b0000, mask_c} << off_c;
        misal_c = ((size_c == SZ_H) && off_c[0]) ||
                  ((size_c == SZ_W) && (off_c != 2'b00));
        split_c = SPLIT_EN && (be8_c[2*BE_W-1:BE_W] != 4'b0000);
        fault_c = !SPLIT_EN && misal_c;
    end

    // Hold decode while idle with a request and for every bus cycle.
    assign o_stall = i_rst_n &&
                     (((state == IDLE) && req_c) || (state == REQ0) || (state == REQ1));

    // Controller FSM with registered bus and result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_ld_data   <= '0;
            o_ld_vld    <= 1'b0;
            o_misalign  <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_be    <= '0;
            load_q      <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SZ_W;
            off_q       <= 2'b00;
            split_q     <= 1'b0;
            be_hi_q     <= '0;
            lo_q        <= '0;
        end else begin
            o_ld_vld   <= 1'b0;
            o_misalign <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_c) begin
                        if (fault_c) begin
                            state      <= FAULT;
                            o_misalign <= 1'b1;
                        end else begin
                            state       <= REQ0;
                            o_bus_req   <= 1'b1;
                            o_bus_we    <= i_mem_wren;
                            o_bus_addr  <= {i_addr[31:2], 2'b00};
                            o_bus_wdata <= i_mem_wren ? wdata_c : '0;
                            o_bus_be    <= be8_c[BE_W-1:0];
                            load_q      <= ~i_mem_wren;
                            uns_q       <= i_l_unsigned;
                            size_q      <= size_c;
                            off_q       <= off_c;
                            split_q     <= split_c;
                            be_hi_q     <= be8_c[2*BE_W-1:BE_W];
                        end
                    end
                end
                REQ0: begin
                    if (i_bus_ack) begin
                        if (split_q) begin
                            // Same store data serves both words: it is already rotated.
                            state      <= REQ1;
                            o_bus_addr <= o_bus_addr + 32'd4;
                            o_bus_be   <= be_hi_q;
                            lo_q       <= i_bus_rdata;
                        end else begin
                            state     <= DONE;
                            o_bus_req <= 1'b0;
                            if (load_q) begin
                                o_ld_data <= load_extract(32'h0, i_bus_rdata, off_q, size_q, uns_q);
                                o_ld_vld  <= 1'b1;
                            end
                        end
                    end
                end
                REQ1: begin
                    if (i_bus_ack) begin
                        state     <= DONE;
                        o_bus_req <= 1'b0;
                        if (load_q) begin
                            o_ld_data <= load_extract(i_bus_rdata, lo_q, off_q, size_q, uns_q);
                            o_ld_vld  <= 1'b1;
                        end
                    end
                end
                DONE, FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 i_mem_rden / i_mem_wren  in  1 each  load / store request from decode; both high is treated as a store.
REQ-004 i_l_length  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other value is treated as LW.
REQ-005 i_l_unsigned  in  1  load zero-extend when high.
REQ-006 i_s_length  in  2  store size: 00 SB, 01 SH, 10 or 11 SW.
REQ-007 i_addr  in  32  byte address; i_st_data  in  32  store data, right-aligned.
REQ-008 o_stall  out  1  pipeline hold.
REQ-009 o_ld_data  out  32  extended load result; o_ld_vld  out  1  result-valid pulse.
REQ-010 o_misalign  out  1  misaligned-access fault pulse.
REQ-011 o_bus_req, o_bus_we  out  1 each; o_bus_addr  out  32, bits [1:0] always 0; o_bus_wdata  out  32; o_bus_be  out  4; i_bus_ack  in  1; i_bus_rdata  in  32.

Function
REQ-012 The FSM SHALL have states IDLE, REQ0, REQ1, DONE and FAULT.
REQ-013 A request is i_mem_rden or i_mem_wren high, sampled only in IDLE.
REQ-014 o_stall SHALL be (IDLE and request) or REQ0 or REQ1; it is low in DONE and FAULT.
REQ-015 IDLE with an accepted access SHALL register address, data, size and sign, and move to REQ0.
REQ-016 IDLE with a faulting access SHALL move to FAULT.
REQ-017 In REQ0/REQ1, o_bus_req is high, and addr/we/wdata/be hold stable until i_bus_ack.
REQ-018 i_bus_ack outside REQ0/REQ1 is ignored.
REQ-019 Ack in REQ0 SHALL go to REQ1 if a second access is needed, else to DONE.
REQ-020 Ack in REQ1 SHALL go to DONE.
REQ-021 DONE and FAULT SHALL each last one cycle, then return to IDLE.
REQ-022 Minimum latency: request to o_ld_vld is 2 cycles, with o_stall high 2 cycles.
REQ-023 Store lane placement: SB sets wdata={4{d[7:0]}} and be=0001<<addr[1:0].
REQ-024 SH sets wdata={2{d[15:0]}} and be=0011<<addr[1:0].
REQ-025 SW sets be=1111, with data rotated left by 8*addr[1:0] when misaligned.
REQ-026 Loads select byte/halfword lanes by addr[1:0], then sign- or zero-extend per i_l_unsigned.
REQ-027 o_ld_data SHALL be registered; o_ld_vld is high in DONE only, and only for loads.
REQ-028 o_misalign SHALL be high in FAULT only; FAULT issues no bus access and produces no o_ld_vld.
REQ-029 o_ld_data SHALL hold its value between loads.

Reset
REQ-030 i_rst_n low SHALL force IDLE immediately, including mid-transaction; o_bus_req drops without waiting for ack.
REQ-031 Reset values: o_stall, o_ld_vld, o_misalign, o_bus_req, o_bus_we = 0; o_ld_data, o_bus_addr, o_bus_wdata = 0; o_bus_be = 0000.

Configuration
REQ-032 Macro LSU_SPLIT_EN undefined: any access not naturally aligned (LH/SH with addr[0]=1, LW/SW with addr[1:0]!=0) faults via FAULT; REQ1 is unreachable.
REQ-033 Macro LSU_SPLIT_EN defined: no fault is raised for any alignment.
REQ-034 With LSU_SPLIT_EN, an access within one word completes in one bus access with shifted be.
REQ-035 With LSU_SPLIT_EN, a word-crossing access (offset + size > 4) uses REQ0 at addr[31:2], then REQ1 at the next word.
REQ-036 With LSU_SPLIT_EN, be is split across the two accesses, and loads merge bytes before extension.
REQ-037 With LSU_SPLIT_EN, next-word address 0xFFFFFFFC wraps to 0x00000000.

Verification
REQ-038 LB, addr 0x103, rdata 0x80FF_FF00, ack in the first REQ0 cycle -> be=1000, o_ld_data=0xFFFFFF80, o_ld_vld one pulse, stall high 2 cycles.
REQ-039 SH, addr 0x202, data 0x0000_BEEF, ack after 3 wait cycles -> we=1, wdata=0xBEEF_BEEF, be=1100, addresses stable throughout, stall high 5 cycles.
REQ-040 LW at 0x101, macro off -> o_misalign one pulse, no o_bus_req, no o_ld_vld.
REQ-041 LW at 0x103, macro on, rdata words 0x44xx_xxxx then 0xxx33_2211 -> two requests to 0x100 and 0x104, o_ld_data=0x33221144.
REQ-042 Reset asserted in REQ0 with ack pending -> o_bus_req=0 and o_stall=0 immediately; next request after release starts cleanly.
REQ-043 rden and wren both high, addr 0x10 -> store performed, o_ld_vld stays 0.
